// File: rtl/div_pkg.sv
// Shared constants and FSM state type for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DefDividendW = 25;
  localparam int unsigned DefDivisorW  = 9;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in the next dividend bit, trial-subtract the divisor,
// keep the difference when it does not borrow.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned DIVISOR_W = DefDivisorW
) (
  input  logic [DIVISOR_W-1:0] rem_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W-1:0] rem_o,
  output logic                 q_bit_o
);

  logic [DIVISOR_W:0]   shifted;
  logic [DIVISOR_W+1:0] trial;

  // Extra top bit of the trial difference is the borrow out.
  always_comb begin
    shifted = {rem_i, bit_i};
    trial   = {1'b0, shifted} - {2'b00, divisor_i};
    q_bit_o = ~trial[DIVISOR_W+1];
    rem_o   = q_bit_o ? trial[DIVISOR_W-1:0] : shifted[DIVISOR_W-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, valid/ready on both sides.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the CALC phase and completes
// one cycle after acceptance with the same result values.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = DefDividendW,
  parameter int unsigned DIVISOR_W  = DefDivisorW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DIVIDEND_W-1:0] dividend_i,
  input  logic [DIVISOR_W-1:0]  divisor_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DIVIDEND_W-1:0] quotient_o,
  output logic [DIVISOR_W-1:0]  remainder_o,
  output logic                  div_by_zero_o
);

  localparam int unsigned     CntW    = $clog2(DIVIDEND_W);
  localparam logic [CntW-1:0] CntLast = CntW'(DIVIDEND_W - 1);

  div_state_e            state_q, state_d;
  // quot_q starts as the dividend; quotient bits shift in at the LSB as dividend bits leave
  // the MSB, so after DIVIDEND_W steps it holds the full quotient.
  logic [DIVIDEND_W-1:0] quot_q, quot_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  dbz_q, dbz_d;

  logic [DIVISOR_W-1:0]  step_rem;
  logic                  step_q;

  div_step #(
    .DIVISOR_W(DIVISOR_W)
  ) u_step (
    .rem_i    (rem_q),
    .bit_i    (quot_q[DIVIDEND_W-1]),
    .divisor_i(divisor_q),
    .rem_o    (step_rem),
    .q_bit_o  (step_q)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;
    cnt_d     = cnt_q;
    dbz_d     = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          quot_d    = dividend_i;
          divisor_d = divisor_i;
          rem_d     = '0;
          cnt_d     = CntLast;
          dbz_d     = (divisor_i == '0);
          state_d   = StCalc;
`ifdef DIV_ZERO_FAST_EN
          // Same values the restoring loop would produce for a zero divisor.
          if (divisor_i == '0) begin
            quot_d  = '1;
            rem_d   = dividend_i[DIVISOR_W-1:0];
            state_d = StDone;
          end
`endif
        end
      end
      StCalc: begin
        quot_d = {quot_q[DIVIDEND_W-2:0], step_q};
        rem_d  = step_rem;
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      quot_q    <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
      cnt_q     <= cnt_d;
      dbz_q     <= dbz_d;
    end
  end

  // Outputs are straight decodes of registered state.
  always_comb begin
    in_ready_o    = (state_q == StIdle);
    out_valid_o   = (state_q == StDone);
    quotient_o    = quot_q;
    remainder_o   = rem_q;
    div_by_zero_o = dbz_q;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential restoring divider: the inverse companion of the 16x9 multiplier datapath. It accepts a 25-bit dividend (product width) and a 9-bit divisor over a valid/ready handshake, and produces one quotient bit per clock. It returns a 25-bit quotient, a 9-bit remainder and a divide-by-zero flag over a second valid/ready handshake. It sits beside the multiplier and is used to check products and to recover operands.

## Interface

Parameters:
- DIVIDEND_W, 25, dividend and quotient width
- DIVISOR_W, 9, divisor and remainder width

Ports (single clock; reset is asynchronous, active-low):
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  divider can accept operands
- dividend  input  DIVIDEND_W  unsigned dividend
- divisor  input  DIVISOR_W  unsigned divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  DIVIDEND_W  unsigned quotient
- remainder  output  DIVISOR_W  unsigned remainder
- div_by_zero  output  1  divisor was zero

## Operation

- FSM has three states: IDLE, CALC, DONE.
- **IDLE**
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: capture dividend and divisor, clear the partial remainder, load the bit counter with DIVIDEND_W-1, go to CALC.
- **CALC**
  - in_ready=0.
  - Each cycle: trial = {rem, next dividend bit MSB-first} − {1'b0, divisor}, DIVISOR_W+1 bits wide.
  - No borrow: rem ← trial[DIVISOR_W-1:0], quotient bit = 1.
  - Borrow: rem ← shifted value[DIVISOR_W-1:0], quotient bit = 0.
  - After DIVIDEND_W steps (counter reaches 0), go to DONE.
- **DONE**
  - out_valid=1. quotient, remainder and div_by_zero stay stable until out_ready.
  - On out_valid&&out_ready, go to IDLE.
  - in_ready=0 in DONE; no accept–complete overlap.
- All arithmetic is unsigned.
- Results satisfy dividend = quotient·divisor + remainder, with remainder < divisor, whenever divisor≠0.
- div_by_zero = (captured divisor == 0). It is registered at acceptance.
- Divide by zero: quotient = all ones, remainder = dividend[DIVISOR_W-1:0]. This is the natural restoring result, and the fast path (see Configuration) reproduces it exactly.
- Reset (asynchronous, any state):
  - State → IDLE.
  - in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0.
  - Any in-flight operation is discarded without output.

## Timing

- Call the acceptance edge t0.
- CALC occupies edges t0+1 … t0+DIVIDEND_W.
- out_valid is high from just after edge t0+DIVIDEND_W, i.e. 25 cycles of latency by default.
- With out_ready held at 1: DONE→IDLE at the next edge, and the next accept one edge later. Minimum issue interval is DIVIDEND_W+2 = 27 cycles.
- in_ready is a function of state only. It never depends combinationally on in_valid or out_ready.
- All outputs are registered.

## Configuration

- Macro: DIV_ZERO_FAST_EN.
- **Defined:** an accept with divisor==0 goes IDLE→DONE directly, with the divide-by-zero result loaded and out_valid high one cycle after t0.
- **Undefined:** a zero divisor runs the full DIVIDEND_W CALC cycles.
- Result values and div_by_zero are identical in both builds. Only latency differs.

## Structure

- Shared package div_pkg holds:
  - default DIVIDEND_W and DIVISOR_W constants;
  - the state enum typedef (IDLE, CALC, DONE).
- One combinational sub-module, div_step, performs a single restoring step:
  - inputs: rem, next bit, divisor;
  - outputs: new rem, quotient bit.
  - It is instantiated once; seq_divider keeps all registers and the FSM.

## Test plan

- 1234567 / 100 → quotient 12345, remainder 67, div_by_zero 0; out_valid exactly 25 cycles after accept.
- 25'h1FFFFFF / 511 → quotient 65664, remainder 127. Also 5 / 9 → quotient 0, remainder 5. Also 25'h1FFFFFF / 1 → quotient 25'h1FFFFFF, remainder 0.
- 25'h0ABCDE / 0 → quotient 25'h1FFFFFF, remainder 222, div_by_zero 1. Latency 1 cycle with DIV_ZERO_FAST_EN, 25 cycles without.
- Backpressure: out_ready low for 10 cycles in DONE → outputs held unchanged, in_ready 0, in_valid pulses ignored. The result is consumed on the first out_ready cycle.
- rst_n asserted at CALC step 12 → out_valid 0 and in_ready 1 immediately (asynchronous), no result emitted. A following 1000/7 → quotient 142, remainder 6.
- Back-to-back: in_valid and out_ready held at 1 across three operations → accepts spaced exactly 27 cycles apart, all results correct.
